// File: rtl/hello_scroll_ctrl.sv
// HELLO scroll controller: message buffer, tick divider and 8-digit window.
// Feeds one character code per digit to the downstream letter decoders.
module hello_scroll_ctrl #(
    parameter int CW       = 3,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int TW       = 26
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [CW-1:0]   wr_data,
    input  logic            len_load,
    input  logic [AW:0]     msg_len,
    input  logic            run,
    input  logic            dir,
    input  logic            step,
    output logic [8*CW-1:0] chars,
    output logic [AW-1:0]   offset,
    output logic            tick
);

    localparam int LEN0 = (DEPTH < 8) ? DEPTH : 8;

    logic [CW-1:0]   mem [DEPTH];
    logic [AW:0]     len;
    logic [TW-1:0]   cnt;
    logic            adv;
    logic            wr_ok;
    logic [AW-1:0]   last;
    logic [AW:0]     len_new;
    logic [AW-1:0]   ptr;
    logic [8*CW-1:0] win;

    assign tick = (cnt == TW'(TICK_DIV - 1));
    assign adv  = (tick & run) | step;
    assign last = AW'(len - 1'b1);

    if (DEPTH < (1 << AW)) begin : g_chk
        assign wr_ok = (32'(wr_addr) < DEPTH);
    end else begin : g_all
        assign wr_ok = 1'b1;
    end

    always_comb begin
        len_new = msg_len;
        if (msg_len == '0)
            len_new = (AW+1)'(1);
        else if (32'(msg_len) > DEPTH)
            len_new = (AW+1)'(DEPTH);
    end

    // Walk the buffer from offset, wrapping at len, HEX7 first.
    always_comb begin
        ptr = offset;
        win = '0;
        for (int k = 7; k >= 0; k--) begin
            win[k*CW +: CW] = mem[ptr];
            ptr = (ptr == last) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= (i < 8) ? CW'(i) : CW'(7);
        end else if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            len    <= (AW+1)'(LEN0);
            offset <= '0;
            cnt    <= '0;
            for (int k = 0; k < 8; k++)
                chars[k*CW +: CW] <= CW'(7 - k);
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            chars <= win;
            if (len_load) begin
                len    <= len_new;
                offset <= '0;
            end else if (adv) begin
                if (dir)
                    offset <= (offset == '0) ? last : offset - 1'b1;
                else
                    offset <= (offset == last) ? '0 : offset + 1'b1;
            end
        end
    end

endmodule
